// File: rtl/gf_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : gf_alu_seq
// Brief    : Handshaked GF(2^m) multiply / power / inverse / divide unit
//            built on a shift/XOR multiplier and square-and-multiply.
// Revision : 1.0  initial release
// ============================================================================
module gf_alu_seq #(
  parameter int SYMB_WIDTH = 8,
  parameter int POLY       = 285,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [SYMB_WIDTH-1:0] in_a,
  input  logic [SYMB_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SYMB_WIDTH-1:0] out_data,
  output logic                  out_err,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int                    c_CNT_W    = $clog2(SYMB_WIDTH);
  localparam logic [SYMB_WIDTH-1:0] c_MASK     = POLY[SYMB_WIDTH-1:0];
  localparam logic [SYMB_WIDTH-1:0] c_ONE      = {{(SYMB_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SYMB_WIDTH-1:0] c_EXP_INV  = {{(SYMB_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [c_CNT_W-1:0]    c_CNT_INIT = c_CNT_W'(SYMB_WIDTH - 2);

  localparam logic [1:0] c_OP_MULT = 2'd0;
  localparam logic [1:0] c_OP_POW  = 2'd1;
  localparam logic [1:0] c_OP_INV  = 2'd2;
  localparam logic [1:0] c_OP_DIV  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXP  = 2'd1,
    S_FIN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_op;
  logic [SYMB_WIDTH-1:0]   r_a;
  logic [SYMB_WIDTH-1:0]   r_base;
  logic [SYMB_WIDTH-1:0]   r_e;
  logic [SYMB_WIDTH-1:0]   r_acc;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [SYMB_WIDTH-1:0]   w_sq;
  logic [SYMB_WIDTH-1:0]   w_step;
  logic [SYMB_WIDTH-1:0]   w_base_in;
  logic [SYMB_WIDTH-1:0]   w_e_in;
  logic [SYMB_WIDTH-1:0]   w_first;

  function automatic logic [SYMB_WIDTH-1:0] gf_mul(
    input logic [SYMB_WIDTH-1:0] x,
    input logic [SYMB_WIDTH-1:0] y
  );
    logic [SYMB_WIDTH-1:0] p;
    p = '0;
    for (int i = SYMB_WIDTH - 1; i >= 0; i--) begin
      p = {p[SYMB_WIDTH-2:0], 1'b0} ^ (p[SYMB_WIDTH-1] ? c_MASK : '0);
      if (y[i]) p = p ^ x;
    end
    return p;
  endfunction

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);

  // The top exponent bit is consumed at accept (1^2 = 1), so EXP needs only
  // m-1 further cycles and the result lands m cycles after accept.
  assign w_base_in = (in_op == c_OP_DIV) ? in_b : in_a;
  assign w_e_in    = (in_op == c_OP_POW) ? in_b : c_EXP_INV;
  assign w_first   = w_e_in[SYMB_WIDTH-1] ? w_base_in : c_ONE;

  assign w_sq   = gf_mul(r_acc, r_acc);
  assign w_step = r_e[r_cnt] ? gf_mul(w_sq, r_base) : w_sq;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = (in_op == c_OP_MULT) ? S_DONE : S_EXP;
      S_EXP:  if (r_cnt == '0) w_state_nxt = (r_op == c_OP_DIV) ? S_FIN : S_DONE;
      S_FIN:  w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op     <= '0;
      r_a      <= '0;
      r_base   <= '0;
      r_e      <= '0;
      r_acc    <= '0;
      r_tag    <= '0;
      r_cnt    <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
      out_tag  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= in_op;
            r_a   <= in_a;
            r_tag <= in_tag;
            if (in_op == c_OP_MULT) begin
              out_data <= gf_mul(in_a, in_b);
              out_err  <= 1'b0;
              out_tag  <= in_tag;
            end else begin
              r_base <= w_base_in;
              r_e    <= w_e_in;
              r_acc  <= w_first;
              r_cnt  <= c_CNT_INIT;
            end
          end
        end
        S_EXP: begin
          r_acc <= w_step;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_op != c_OP_DIV) begin
            out_data <= w_step;
            out_err  <= (r_op == c_OP_INV) && (r_base == '0);
            out_tag  <= r_tag;
          end
        end
        S_FIN: begin
          // b = 0 leaves r_acc = 0, so the product is already the required 0.
          out_data <= gf_mul(r_a, r_acc);
          out_err  <= (r_base == '0);
          out_tag  <= r_tag;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf_alu_seq.sv
`default_nettype none
// Testbench for gf_alu_seq: m=8 and m=4 instances checked against an
// arithmetic model built from carry-less products and brute-force inverses.
module tb_gf_alu_seq;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // m = 8 instance
  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
  logic [1:0] in_op = '0;
  logic [7:0] in_a = '0, in_b = '0, out_data;
  logic [3:0] in_tag = '0, out_tag;

  // m = 4 instance
  logic       v4 = 1'b0, rdy4, ov4, ordy4 = 1'b0, err4;
  logic [1:0] op4 = '0;
  logic [3:0] a4 = '0, b4 = '0, d4;
  logic [3:0] tag4 = '0, t4;

  gf_alu_seq #(.SYMB_WIDTH(8), .POLY(285), .TAG_WIDTH(4)) dut8 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_tag(out_tag));

  gf_alu_seq #(.SYMB_WIDTH(4), .POLY(19), .TAG_WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(v4), .in_ready(rdy4),
    .in_op(op4), .in_a(a4), .in_b(b4), .in_tag(tag4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(d4),
    .out_err(err4), .out_tag(t4));

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int gmul(input int a, input int b, input int m, input int poly);
    int p = 0;
    for (int i = 0; i < m; i++) if ((b >> i) & 1) p ^= (a << i);
    for (int i = 2 * m - 2; i >= m; i--) if ((p >> i) & 1) p ^= (poly << (i - m));
    return p;
  endfunction

  function automatic int gpow(input int a, input int e, input int m, input int poly);
    int r = 1;
    for (int i = 0; i < e; i++) r = gmul(r, a, m, poly);
    return r;
  endfunction

  function automatic int ginv(input int a, input int m, input int poly);
    for (int x = 1; x < (1 << m); x++) if (gmul(a, x, m, poly) == 1) return x;
    return 0;
  endfunction

  task automatic model(input int op, input int a, input int b, input int m, input int poly,
                       output int d, output int e, output int lat);
    e = 0;
    case (op)
      0: begin d = gmul(a, b, m, poly); lat = 1; end
      1: begin d = gpow(a, b, m, poly); lat = m; end
      2: begin lat = m; if (a == 0) begin d = 0; e = 1; end else d = ginv(a, m, poly); end
      default: begin
        lat = m + 1;
        if (b == 0) begin d = 0; e = 1; end
        else d = gmul(a, ginv(b, m, poly), m, poly);
      end
    endcase
  endtask

  // ---------------- m = 8 drivers ----------------
  task automatic issue8(input int op, input int a, input int b, input int tag);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    check("issue_ready8", in_ready, 1);
    in_valid = 1'b1; in_op = op[1:0]; in_a = a[7:0]; in_b = b[7:0]; in_tag = tag[3:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 1;
    while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic txn8(input string name, input int op, input int a, input int b, input int tag);
    int lat, ed, ee, el;
    model(op, a, b, 8, 285, ed, ee, el);
    issue8(op, a, b, tag);
    wait_valid8(lat);
    check({name, "_lat"}, lat, el);
    check({name, "_data"}, out_data, ed);
    check({name, "_err"}, out_err, ee);
    check({name, "_tag"}, out_tag, tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  // ---------------- m = 4 driver ----------------
  task automatic run4(input int op, input int a, input int b, output int d, output int e, output int lat);
    int n = 0;
    while (!rdy4 && n < 100) begin @(posedge clk); #1; n++; end
    v4 = 1'b1; op4 = op[1:0]; a4 = a[3:0]; b4 = b[3:0]; tag4 = 4'h3;
    @(posedge clk); #1;
    v4 = 1'b0;
    lat = 1;
    while (!ov4 && lat < 64) begin @(posedge clk); #1; lat++; end
    d = int'(d4); e = int'(err4);
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
  endtask

  initial begin
    int lat, d, e, el, ed, ee;
    logic [7:0] hd;
    logic       he;
    logic [3:0] ht;
    logic       spur;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {in_ready, out_valid, out_err, out_data, out_tag}, {1'b1, 1'b0, 1'b0, 8'h00, 4'h0});
    rstn = 1'b1;
    @(posedge clk); #1;

    // directed MULT / POW / INV / DIV
    txn8("mul_03_07", 0, 8'h03, 8'h07, 1);
    check("mul_03_07_const", out_data, 8'h09);
    txn8("mul_80_02", 0, 8'h80, 8'h02, 2);
    check("mul_80_02_const", out_data, 8'h1D);
    txn8("mul_00_ff", 0, 8'h00, 8'hFF, 3);
    txn8("pow_02_8", 1, 8'h02, 8, 4);
    check("pow_02_8_const", out_data, 8'h1D);
    txn8("pow_02_0", 1, 8'h02, 0, 5);
    txn8("pow_00_0", 1, 8'h00, 0, 6);
    check("pow_00_0_const", out_data, 8'h01);
    txn8("pow_00_5", 1, 8'h00, 5, 7);
    txn8("pow_57_255", 1, 8'h57, 255, 8);
    check("pow_57_255_const", out_data, 8'h01);
    txn8("inv_02", 2, 8'h02, 0, 9);
    check("inv_02_const", out_data, 8'h8E);
    txn8("div_1d_02", 3, 8'h1D, 8'h02, 10);
    check("div_1d_02_const", out_data, 8'h80);
    txn8("div_01_00", 3, 8'h01, 8'h00, 11);
    check("div_01_00_err", {out_err, out_data}, 9'h100);
    txn8("inv_00", 2, 8'h00, 0, 12);
    txn8("div_00_05", 3, 8'h00, 8'h05, 13);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      int op, a, b;
      op = int'($urandom_range(0, 3));
      a  = int'($urandom_range(0, 255));
      b  = (($urandom & 7) == 0) ? 0 : int'($urandom_range(0, 255));
      txn8("rand", op, a, b, int'($urandom_range(0, 15)));
    end

    // backpressure on a DIV result with a competing request pending
    model(3, 8'h1D, 8'h02, 8, 285, ed, ee, el);
    issue8(3, 8'h1D, 8'h02, 5);
    wait_valid8(lat);
    check("bp_lat", lat, el);
    hd = out_data; he = out_err; ht = out_tag;
    check("bp_first", {ht, hd}, {4'h5, 8'h80});
    in_valid = 1'b1; in_op = 2'd0; in_a = 8'h03; in_b = 8'h07; in_tag = 4'h9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {out_valid, in_ready, out_err, out_data, out_tag}, {1'b1, 1'b0, he, hd, ht});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_idle", {out_valid, in_ready}, 2'b01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second", {out_valid, out_tag, out_data}, {1'b1, 4'h9, 8'h09});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // reset in the middle of a POW
    issue8(1, 8'h57, 8'hC3, 4'hA);
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("midrst_outs", {in_ready, out_valid, out_err, out_data, out_tag}, {1'b1, 1'b0, 1'b0, 8'h00, 4'h0});
    @(posedge clk); #1;
    rstn = 1'b1;
    spur = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      spur = spur | out_valid;
    end
    check("midrst_no_valid", {spur, in_ready}, 2'b01);
    txn8("post_rst", 1, 8'h57, 8'hC3, 4'hB);

    // m = 4 instance
    run4(2, 4'h2, 0, d, e, lat);
    check("m4_inv2", {lat[7:0], 3'b0, e[0], d[3:0]}, {8'd4, 4'h0, 4'h9});
    for (int a = 1; a < 16; a++) begin
      int iv;
      run4(2, a, 0, iv, e, lat);
      run4(0, a, iv, d, e, lat);
      check("m4_a_times_inv", d, 1);
    end
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run4(0, a, b, d, e, lat);
        check("m4_mul", d, gmul(a, b, 4, 19));
      end
    end
    run4(3, 4'h7, 4'h0, d, e, lat);
    check("m4_div0", {lat[7:0], 3'b0, e[0], d[3:0]}, {8'd5, 4'h1, 4'h0});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
